// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decode plus HI/LO registers and an iterative one-bit-per-clock
// multiply/divide engine that stalls dependent HI/LO instructions while it runs.
module alu_muldiv_ctrl #(
   parameter int                   WIDTH     = 32,
   parameter int                   ALUOP_W   = 4,
   parameter logic [ALUOP_W-1:0]   R_TYPE_OP = {ALUOP_W{1'b1}}
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   input  logic [ALUOP_W-1:0] alu_op_i,
   input  logic [5:0]         func_code_i,
   input  logic [WIDTH-1:0]   op_a_i,
   input  logic [WIDTH-1:0]   op_b_i,
   output logic [ALUOP_W-1:0] alu_ctrl_o,
   output logic               sll_ctrl_o,
   output logic               hilo_rd_o,
   output logic [WIDTH-1:0]   hilo_data_o,
   output logic               stall_o,
   output logic               busy_o,
   output logic               div_by_zero_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
   localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTLO = 6'b010011;

   typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   up_q, up_d, dn_q, dn_d, b_q, b_d;
   logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
   logic               dz_q, dz_d;

   logic               r_type, hilo_op, md_op, is_div, sign_a, sign_b, div_zero;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_mag, prod_fix;

   // ---------------- decode ----------------
   assign r_type = (alu_op_i == R_TYPE_OP);

   always_comb begin
      alu_ctrl_o = alu_op_i;
      sll_ctrl_o = 1'b0;
      hilo_rd_o  = 1'b0;
      if (r_type) begin
         sll_ctrl_o = (func_code_i == F_SLL) || (func_code_i == F_SRL) || (func_code_i == F_SRA);
         hilo_rd_o  = (func_code_i == F_MFHI) || (func_code_i == F_MFLO);
         case (func_code_i)
            F_SLL:   alu_ctrl_o = ALUOP_W'(4'b0011);
            F_SRL:   alu_ctrl_o = ALUOP_W'(4'b0100);
            F_SRA:   alu_ctrl_o = ALUOP_W'(4'b1101);
            F_ADD:   alu_ctrl_o = ALUOP_W'(4'b0010);
            F_ADDU:  alu_ctrl_o = ALUOP_W'(4'b1000);
            F_SUB:   alu_ctrl_o = ALUOP_W'(4'b0110);
            F_SUBU:  alu_ctrl_o = ALUOP_W'(4'b1001);
            F_AND:   alu_ctrl_o = ALUOP_W'(4'b0000);
            F_OR:    alu_ctrl_o = ALUOP_W'(4'b0001);
            F_XOR:   alu_ctrl_o = ALUOP_W'(4'b1010);
            F_NOR:   alu_ctrl_o = ALUOP_W'(4'b1100);
            F_SLT:   alu_ctrl_o = ALUOP_W'(4'b0111);
            F_SLTU:  alu_ctrl_o = ALUOP_W'(4'b1011);
            default: alu_ctrl_o = '0;
         endcase
      end
   end

   // ---------------- engine control ----------------
   // 0100xx covers MFHI/MTHI/MFLO/MTLO, 0110xx covers MULT/MULTU/DIV/DIVU.
   assign md_op    = (func_code_i[5:2] == 4'b0110);
   assign hilo_op  = valid_i & r_type & ((func_code_i[5:2] == 4'b0100) | md_op);
   assign is_div   = func_code_i[1];
   assign sign_a   = ~func_code_i[0] & op_a_i[WIDTH-1];
   assign sign_b   = ~func_code_i[0] & op_b_i[WIDTH-1];
   assign abs_a    = sign_a ? -op_a_i : op_a_i;
   assign abs_b    = sign_b ? -op_b_i : op_b_i;
   assign div_zero = is_div & (op_b_i == '0);

   assign busy_o        = (state_q != IDLE);
   assign stall_o       = hilo_op & busy_o;
   assign hilo_data_o   = (r_type && func_code_i == F_MFHI) ? hi_q : lo_q;
   assign div_by_zero_o = dz_q;

   // up_q/dn_q hold product high/low during multiply, remainder/quotient during divide.
   assign mul_sum   = {1'b0, up_q} + (dn_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {up_q, dn_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_q};
   assign prod_mag  = {up_q, dn_q};
   assign prod_fix  = neg_q ? -prod_mag : prod_mag;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      up_d    = up_q;
      dn_d    = dn_q;
      b_d     = b_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (hilo_op && md_op) begin
               if (div_zero) begin
                  dz_d = 1'b1;
               end else begin
                  state_d = RUN;
                  cnt_d   = '0;
                  up_d    = '0;
                  dn_d    = abs_a;
                  b_d     = abs_b;
                  div_d   = is_div;
                  neg_d   = sign_a ^ sign_b;
                  rneg_d  = sign_a;
               end
            end else if (hilo_op && func_code_i == F_MTHI) begin
               hi_d = op_a_i;
            end else if (hilo_op && func_code_i == F_MTLO) begin
               lo_d = op_a_i;
            end
         end
         RUN: begin
            if (div_q) begin
               if (!div_diff[WIDTH]) begin
                  up_d = div_diff[WIDTH-1:0];
                  dn_d = {dn_q[WIDTH-2:0], 1'b1};
               end else begin
                  up_d = div_shift[WIDTH-1:0];
                  dn_d = {dn_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               up_d = mul_sum[WIDTH:1];
               dn_d = {mul_sum[0], dn_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_d = FIXUP;
         end
         FIXUP: begin
            if (div_q) begin
               lo_d = neg_q  ? -dn_q : dn_q;
               hi_d = rneg_q ? -up_q : up_q;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         up_q    <= '0;
         dn_q    <= '0;
         b_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
         b_q     <= b_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

endmodule
